// File: rtl/systolic_array_n.sv
// N x N weight-stationary systolic matrix multiplier, signed fixed point.
// Callers present whole A rows and receive whole, aligned A_row x W rows after 2N cycles.
// Weights are double-buffered: rows stream into a shadow bank while the active bank computes.
module systolic_array_n #(
    parameter int unsigned N    = 4,
    parameter int unsigned DW   = 16,
    parameter int unsigned FRAC = 8,
    parameter int unsigned ACCW = 2 * DW + $clog2(N)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            w_valid,
    input  logic [N*DW-1:0] w_row,
    output logic            w_ready,
    output logic            w_full,
    input  logic            switch_in,
    output logic            sw_ready,
    input  logic            in_valid,
    input  logic [N*DW-1:0] in_data,
    output logic            busy,
    output logic            out_valid,
    output logic [N*DW-1:0] out_data,
    output logic [N-1:0]    out_sat
);

    localparam int unsigned PW = $clog2(N);
    // Valid stages from the input register to the last deskew stage.
    localparam int unsigned VD = 2 * N;

    typedef logic signed [DW-1:0]   data_t;
    typedef logic signed [2*DW-1:0] prod_t;
    typedef logic signed [ACCW-1:0] acc_t;

    localparam acc_t SatMax = acc_t'({1'b0, {(DW - 1){1'b1}}});
    localparam acc_t SatMin = -SatMax - acc_t'(1);

    // Weight banks
    data_t         w_shadow_q [N][N];
    data_t         w_active_q [N][N];
    logic [PW-1:0] wptr_q;
    logic          w_full_q;
    logic          w_accept;
    logic          sw_accept;

    // Datapath
    data_t skew_q  [N][N];  // row k uses stages 0..k
    data_t a_q     [N][N];  // a value leaving PE(k,j) to the right
    acc_t  psum_q  [N][N];  // partial sum leaving PE(k,j) downwards
    acc_t  dsk_q   [N][N];  // column j uses stages 0..N-2-j
    data_t a_in    [N][N];
    acc_t  psum_in [N][N];
    acc_t  prod    [N][N];
    acc_t  col_sum [N];
    acc_t  shifted [N];

    // Valids and output register
    logic [VD-1:0]   vld_q;
    logic            out_valid_q;
    logic [N*DW-1:0] out_data_q;
    logic [N-1:0]    out_sat_q;
    logic [N*DW-1:0] out_data_d;
    logic [N-1:0]    out_sat_d;

    assign busy      = (|vld_q) | out_valid_q;
    assign w_full    = w_full_q;
    assign w_ready   = !w_full_q;
    assign sw_ready  = w_full_q && !busy;
    assign w_accept  = w_valid && !w_full_q;
    assign sw_accept = switch_in && w_full_q && !busy;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_sat   = out_sat_q;

    // Shadow loading, write pointer and bank swap; a swap only happens when nothing is in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_q   <= '0;
            w_full_q <= 1'b0;
            for (int k = 0; k < int'(N); k++) begin
                for (int j = 0; j < int'(N); j++) begin
                    w_shadow_q[k][j] <= '0;
                    w_active_q[k][j] <= '0;
                end
            end
        end else if (sw_accept) begin
            for (int k = 0; k < int'(N); k++) begin
                for (int j = 0; j < int'(N); j++) begin
                    w_active_q[k][j] <= w_shadow_q[k][j];
                end
            end
            w_full_q <= 1'b0;
            wptr_q   <= '0;
        end else if (w_accept) begin
            for (int j = 0; j < int'(N); j++) begin
                w_shadow_q[wptr_q][j] <= w_row[j*DW +: DW];
            end
            if (wptr_q == PW'(N - 1)) begin
                wptr_q   <= '0;
                w_full_q <= 1'b1;
            end else begin
                wptr_q <= wptr_q + 1'b1;
            end
        end
    end

    // PE inputs and products; index guards keep dead branches in range.
    always_comb begin
        for (int k = 0; k < int'(N); k++) begin
            for (int j = 0; j < int'(N); j++) begin
                a_in[k][j]    = (j == 0) ? skew_q[k][k] : a_q[k][(j > 0) ? j - 1 : 0];
                psum_in[k][j] = (k == 0) ? '0 : psum_q[(k > 0) ? k - 1 : 0][j];
                prod[k][j]    = acc_t'(prod_t'(a_in[k][j]) * prod_t'(w_active_q[k][j]));
            end
        end
    end

    // Input skew, PE array and output deskew registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < int'(N); k++) begin
                for (int j = 0; j < int'(N); j++) begin
                    skew_q[k][j] <= '0;
                    a_q[k][j]    <= '0;
                    psum_q[k][j] <= '0;
                    dsk_q[k][j]  <= '0;
                end
            end
        end else begin
            for (int k = 0; k < int'(N); k++) begin
                skew_q[k][0] <= in_data[k*DW +: DW];
                for (int d = 1; d < int'(N); d++) begin
                    skew_q[k][d] <= skew_q[k][d-1];
                end
                for (int j = 0; j < int'(N); j++) begin
                    a_q[k][j]    <= a_in[k][j];
                    psum_q[k][j] <= psum_in[k][j] + prod[k][j];
                end
            end
            for (int j = 0; j < int'(N); j++) begin
                dsk_q[j][0] <= psum_q[N-1][j];
                for (int d = 1; d < int'(N); d++) begin
                    dsk_q[j][d] <= dsk_q[j][d-1];
                end
            end
        end
    end

    // Aligned column sums, rescaled and saturated; zero whenever no row is leaving.
    always_comb begin
        out_data_d = '0;
        out_sat_d  = '0;
        for (int j = 0; j < int'(N); j++) begin
            col_sum[j] = (j == int'(N) - 1) ? psum_q[N-1][j]
                                            : dsk_q[j][(j < int'(N) - 1) ? int'(N) - 2 - j : 0];
            shifted[j] = col_sum[j] >>> FRAC;
            if (vld_q[VD-1]) begin
                if (shifted[j] > SatMax) begin
                    out_data_d[j*DW +: DW] = SatMax[DW-1:0];
                    out_sat_d[j]           = 1'b1;
                end else if (shifted[j] < SatMin) begin
                    out_data_d[j*DW +: DW] = SatMin[DW-1:0];
                    out_sat_d[j]           = 1'b1;
                end else begin
                    out_data_d[j*DW +: DW] = shifted[j][DW-1:0];
                end
            end
        end
    end

    // Valid shift chain and output register.
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q       <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_sat_q   <= '0;
        end else begin
            vld_q       <= {vld_q[VD-2:0], in_valid};
            out_valid_q <= vld_q[VD-1];
            out_data_q  <= out_data_d;
            out_sat_q   <= out_sat_d;
        end
    end

endmodule

// File: tb/tb_systolic_array_n.sv
// Directed self-checking bench for systolic_array_n (N=2 and N=4 instances).
module tb_systolic_array_n;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;

    // N = 2 instance
    logic        w_valid, switch_in, in_valid;
    logic [31:0] w_row, in_data;
    logic        w_ready, w_full, sw_ready, busy, out_valid;
    logic [31:0] out_data;
    logic [1:0]  out_sat;

    // N = 4 instance
    logic        w_valid_4, switch_in_4, in_valid_4;
    logic [63:0] w_row_4, in_data_4;
    logic        w_ready_4, w_full_4, sw_ready_4, busy_4, out_valid_4;
    logic [63:0] out_data_4;
    logic [3:0]  out_sat_4;

    int n_checks = 0;
    int n_errors = 0;

    systolic_array_n #(.N(2), .DW(16), .FRAC(8)) dut2 (
        .clk(clk), .rst(rst),
        .w_valid(w_valid), .w_row(w_row), .w_ready(w_ready), .w_full(w_full),
        .switch_in(switch_in), .sw_ready(sw_ready),
        .in_valid(in_valid), .in_data(in_data), .busy(busy),
        .out_valid(out_valid), .out_data(out_data), .out_sat(out_sat)
    );

    systolic_array_n #(.N(4), .DW(16), .FRAC(8)) dut4 (
        .clk(clk), .rst(rst),
        .w_valid(w_valid_4), .w_row(w_row_4), .w_ready(w_ready_4), .w_full(w_full_4),
        .switch_in(switch_in_4), .sw_ready(sw_ready_4),
        .in_valid(in_valid_4), .in_data(in_data_4), .busy(busy_4),
        .out_valid(out_valid_4), .out_data(out_data_4), .out_sat(out_sat_4)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] pack2(input logic [15:0] e0, input logic [15:0] e1);
        return {e1, e0};
    endfunction

    task automatic load2(input logic [31:0] row);
        w_valid = 1'b1;
        w_row   = row;
        tick();
        w_valid = 1'b0;
        w_row   = '0;
    endtask

    task automatic switch2();
        switch_in = 1'b1;
        tick();
        switch_in = 1'b0;
    endtask

    // One isolated row; result expected exactly 4 edges after the sampling edge.
    task automatic run_row2(input logic sw, input logic [31:0] row, input logic [31:0] exp_d,
                            input logic [1:0] exp_s, input string tag);
        in_valid  = 1'b1;
        in_data   = row;
        switch_in = sw;
        tick();
        in_valid  = 1'b0;
        in_data   = '0;
        switch_in = 1'b0;
        for (int c = 1; c < 4; c++) begin
            tick();
            check({tag, "_early"}, out_valid, 1'b0);
        end
        tick();
        check({tag, "_valid"}, out_valid, 1'b1);
        check({tag, "_data"}, out_data, exp_d);
        check({tag, "_sat"}, out_sat, exp_s);
        tick();
        check({tag, "_done"}, out_valid, 1'b0);
        check({tag, "_idle"}, busy, 1'b0);
    endtask

    logic [31:0] rows2 [4];
    logic [63:0] rows4 [4];
    logic        seen;

    initial begin
        rst = 1'b1;
        w_valid = 0; switch_in = 0; in_valid = 0; w_row = '0; in_data = '0;
        w_valid_4 = 0; switch_in_4 = 0; in_valid_4 = 0; w_row_4 = '0; in_data_4 = '0;
        tick();
        tick();

        // 1. Reset state
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_out_data", out_data, 32'h0);
        check("rst_w_ready", w_ready, 1'b1);
        check("rst_w_full", w_full, 1'b0);
        check("rst_sw_ready", sw_ready, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst4_w_ready", w_ready_4, 1'b1);
        rst = 1'b0;
        tick();

        // 2. Identity weights, four back-to-back rows; 3. shadow load during flight
        load2(pack2(16'h0100, 16'h0000));
        check("id_w_full_mid", w_full, 1'b0);
        load2(pack2(16'h0000, 16'h0100));
        check("id_w_full", w_full, 1'b1);
        check("id_sw_ready", sw_ready, 1'b1);
        switch2();
        check("id_after_sw_full", w_full, 1'b0);
        rows2[0] = pack2(16'h0100, 16'h0200);
        rows2[1] = pack2(16'h0300, 16'h0400);
        rows2[2] = pack2(16'h0500, 16'h0600);
        rows2[3] = pack2(16'h0700, 16'h0800);
        for (int i = 0; i < 12; i++) begin
            if (i < 4) begin
                in_valid = 1'b1;
                in_data  = rows2[i];
            end else begin
                in_valid = 1'b0;
                in_data  = '0;
            end
            w_valid   = (i < 2);
            w_row     = (i == 0) ? pack2(16'h0200, 16'h0000) : pack2(16'h0000, 16'h0080);
            switch_in = (i == 3);
            tick();
            check("stream_valid", out_valid, (i >= 4 && i < 8));
            if (i >= 4 && i < 8) begin
                check("stream_data", out_data, rows2[i-4]);
                check("stream_sat", out_sat, 2'b00);
            end
            if (i == 2) begin
                check("db_w_full", w_full, 1'b1);
                check("db_sw_ready_busy", sw_ready, 1'b0);
                check("db_busy", busy, 1'b1);
            end
            if (i == 7) check("stream_busy_last", busy, 1'b1);
            if (i == 8) check("stream_busy_drained", busy, 1'b0);
        end
        w_valid = 1'b0;
        w_row   = '0;
        check("db_dropped_full", w_full, 1'b1);
        check("db_sw_ready", sw_ready, 1'b1);
        run_row2(1'b1, pack2(16'h0100, 16'h0200), pack2(16'h0200, 16'h0100), 2'b00, "db");
        check("db_after_sw_full", w_full, 1'b0);

        // Mixed signs across the reduction: W=[[1,2],[-1,0.5]], a=[3,2] -> [1,7]
        load2(pack2(16'h0100, 16'h0200));
        load2(pack2(16'hFF00, 16'h0080));
        run_row2(1'b1, pack2(16'h0300, 16'h0200), pack2(16'h0100, 16'h0700), 2'b00, "mix");

        // 4. Saturation both ways
        load2(pack2(16'h7F00, 16'h7F00));
        load2(pack2(16'h7F00, 16'h7F00));
        run_row2(1'b1, pack2(16'h7F00, 16'h7F00), pack2(16'h7FFF, 16'h7FFF), 2'b11, "sat_pos");
        run_row2(1'b0, pack2(16'h8100, 16'h8100), pack2(16'h8000, 16'h8000), 2'b11, "sat_neg");

        // 5. Floor on the arithmetic shift
        load2(pack2(16'hFF80, 16'h0000));
        load2(pack2(16'h0000, 16'h0000));
        run_row2(1'b1, pack2(16'h0001, 16'h0000), pack2(16'hFFFF, 16'h0000), 2'b00, "floor");

        // 6. Reset mid-stream discards everything and clears the active bank
        load2(pack2(16'h0100, 16'h0000));
        load2(pack2(16'h0000, 16'h0100));
        switch2();
        seen = 1'b0;
        for (int i = 0; i < 16; i++) begin
            in_valid = (i < 3);
            in_data  = (i < 3) ? rows2[0] : '0;
            rst      = (i == 3);
            tick();
            if (out_valid) seen = 1'b1;
        end
        rst = 1'b0;
        check("rstmid_no_output", seen, 1'b0);
        check("rstmid_busy", busy, 1'b0);
        check("rstmid_w_full", w_full, 1'b0);
        run_row2(1'b0, pack2(16'h0100, 16'h0200), 32'h0, 2'b00, "rstmid_zero_w");

        // N = 4 identity, latency 8
        for (int k = 0; k < 4; k++) begin
            w_valid_4 = 1'b1;
            w_row_4   = '0;
            w_row_4[k*16 +: 16] = 16'h0100;
            tick();
        end
        w_valid_4 = 1'b0;
        w_row_4   = '0;
        check("n4_w_full", w_full_4, 1'b1);
        switch_in_4 = 1'b1;
        tick();
        switch_in_4 = 1'b0;
        for (int r = 0; r < 4; r++) begin
            for (int k = 0; k < 4; k++) begin
                rows4[r][k*16 +: 16] = 16'((4 * r + k + 1) * 256);
            end
        end
        rows4[2][16 +: 16] = 16'hFD00;  // a negative element passes through unchanged
        for (int i = 0; i < 16; i++) begin
            if (i < 4) begin
                in_valid_4 = 1'b1;
                in_data_4  = rows4[i];
            end else begin
                in_valid_4 = 1'b0;
                in_data_4  = '0;
            end
            tick();
            check("n4_valid", out_valid_4, (i >= 8 && i < 12));
            if (i >= 8 && i < 12) begin
                check("n4_data", out_data_4, rows4[i-8]);
                check("n4_sat", out_sat_4, 4'b0000);
            end
            if (i == 0) check("n4_busy", busy_4, 1'b1);
            if (i == 12) check("n4_busy_drained", busy_4, 1'b0);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/systolic_array_n.md
Name: systolic_array_n

Overview:
- Parametrised N x N weight-stationary systolic matrix-multiply array in signed fixed point. It is the generalised successor of the 2x2 systolic block.
- Accepts one row vector of A per cycle and returns the row vector A_row x W after a fixed latency.
- Input skewing and output deskewing are done internally, so callers present and receive whole, aligned rows.
- Weights are double-buffered: a shadow bank loads while the active bank computes.

Parameters:
- N, 4, array dimension (rows = columns = reduction length K), N >= 2
- DW, 16, data/weight/output width, signed two's complement
- FRAC, 8, fractional bits (Q(DW-FRAC).FRAC)
- ACCW, 2*DW+$clog2(N), internal accumulator width

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  synchronous, active-high reset
- w_valid  in  1  weight row beat valid
- w_row  in  N*DW  weight row k; element j at bits [j*DW +: DW]
- w_ready  out  1  shadow bank accepting rows (= !w_full)
- w_full  out  1  shadow bank holds N rows
- switch_in  in  1  request shadow -> active bank swap
- sw_ready  out  1  swap would be accepted this cycle (w_full && !busy)
- in_valid  in  1  A row valid; no backpressure, always accepted
- in_data  in  N*DW  A row; element k at bits [k*DW +: DW]
- busy  out  1  any valid data in flight (skew, PE array or deskew)
- out_valid  out  1  result row valid
- out_data  out  N*DW  result row; column j at bits [j*DW +: DW]
- out_sat  out  N  per-column saturation occurred for this row

Behaviour:
- Reset (synchronous):
  - All active and shadow weights = 0; write pointer = 0; w_full = 0.
  - All pipeline valids and data = 0; out_valid = 0, out_data = 0, out_sat = 0.
  - Reset asserted mid-operation discards all in-flight rows. No output is produced for them.
- Weight load:
  - A beat is accepted when w_valid && w_ready. It writes shadow[wptr][0..N-1], then wptr increments.
  - On the Nth accepted beat, wptr wraps to 0 and w_full = 1 from the next cycle.
  - While w_full, w_valid is ignored.
- Switch:
  - Accepted only when switch_in && w_full && !busy.
  - On the accepting edge: active <= shadow, w_full <= 0, wptr <= 0.
  - A switch_in that is not accepted is dropped, not queued.
  - If in_valid is high in the same cycle as an accepted switch, that row computes with the NEW weights.
- Dataflow:
  - PE(k,j) holds W[k][j]. a_k enters row k after an internal skew of k cycles and moves right one PE per cycle.
  - Partial sums move down one PE per cycle. psum_out = psum_in + a*W at full 2*DW product precision, sign-extended to ACCW.
  - Column j result leaves the bottom row and is delayed N-1-j cycles, so all columns align.
- Latency:
  - out_valid is asserted exactly 2N cycles after the edge that sampled in_valid.
  - Back-to-back inputs produce back-to-back outputs in order.
  - Input gaps are reproduced as gaps in out_valid.
- Output arithmetic:
  - sum >>> FRAC (arithmetic shift, truncation toward -inf).
  - The result is then saturated to [-2^(DW-1), 2^(DW-1)-1]; out_sat[j] = 1 when clamping occurred.
  - While out_valid = 0, out_data and out_sat hold 0.
- busy: high from the cycle after an in_valid is sampled until the cycle its out_valid is asserted, inclusive. It is the OR of all internal valid bits.
- Weight bank usage: the active bank never changes while busy, and the shadow bank never affects computation.

Test Plan (N=2, DW=16, FRAC=8 unless stated):
1. Reset -> out_valid=0, out_data=0, w_ready=1, w_full=0, sw_ready=0, busy=0.
2. Load W=[[0x0100,0],[0,0x0100]], switch, then stream rows [1,2],[3,4],[5,6],[7,8] on consecutive cycles -> 4 consecutive out_valid cycles starting exactly 4 cycles after the first input, with identical rows and out_sat=00.
3. Double-buffer:
   - While test 2's stream is in flight, load W2=[[2.0,0],[0,0.5]]; w_full=1 and switch_in during busy is dropped (sw_ready=0).
   - After drain, switch is accepted; row [1,2] -> [2.0,1.0] (0x0200,0x0100).
4. Saturation: W all 0x7F00, row [0x7F00,0x7F00] -> out 0x7FFF,0x7FFF, out_sat=11. Row [0x8100,0x8100] -> 0x8000,0x8000, out_sat=11.
5. Rounding: W00=0xFF80 (-0.5), others 0; row [0x0001,0] -> column 0 = 0xFFFF (floor), column 1 = 0.
6. Reset mid-stream: assert rst 2 cycles after streaming 3 rows -> no out_valid ever appears; active weights are 0 (a new row after reset without a load returns 0). Repeat test 2 with N=4 identity, where latency = 8.
